// File: rtl/seq_divider_pkg.sv
// ============================================================================
// Module      : seq_divider_pkg
// Description : Shared state encoding and default width for the sequential
//               restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_divider_pkg;

    localparam int c_default_w = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider_trial_sign_eval.sv
// ============================================================================
// Module      : trial_sign_eval
// Description : Combinational W+1-bit trial subtraction with sign and zero
//               status for the restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trial_sign_eval #(
    parameter int W = 32
) (
    input  logic [W:0]   i_rem_shifted,
    input  logic [W-1:0] i_divisor,
    output logic [W:0]   o_trial,
    output logic         o_neg,
    output logic         o_zero
);

    assign o_trial = i_rem_shifted - {1'b0, i_divisor};
    assign o_neg   = o_trial[W];
    assign o_zero  = (o_trial == '0);

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Iterative unsigned restoring divider, one quotient bit per
//               clock, with start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int W  = c_default_w,
    parameter int CW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    state_t         r_state;
    state_t         w_next_state;
    logic [W:0]     r_rem;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_d;
    logic [CW-1:0]  r_count;

    logic [W:0]     w_rem_shift;
    logic [W:0]     w_trial;
    logic           w_neg;
    logic           w_zero;
    logic [W:0]     w_rem_step;
    logic [W-1:0]   w_q_step;
    logic           w_last_step;
    logic           w_unused;

    assign w_rem_shift = {r_rem[W-1:0], r_q[W-1]};
    assign w_rem_step  = w_neg ? w_rem_shift : w_trial;
    assign w_q_step    = {r_q[W-2:0], ~w_neg};
    assign w_last_step = (r_count == CW'(1));

    // The zero flag is a debug export only; R's top bit is always 0 between steps.
    assign w_unused = &{1'b0, w_zero, r_rem[W]};

    trial_sign_eval #(
        .W (W)
    ) u_trial (
        .i_rem_shifted (w_rem_shift),
        .i_divisor     (r_d),
        .o_trial       (w_trial),
        .o_neg         (w_neg),
        .o_zero        (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: w_next_state = start ? LOAD : IDLE;
            LOAD:       w_next_state = (r_d == '0) ? DONE : ITER;
            ITER:       if (w_last_step) w_next_state = DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    assign busy = (r_state == LOAD) || (r_state == ITER);
    assign done = (r_state == DONE);

    // Result registers only move on the transition into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_count     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_q   <= dividend;
                        r_d   <= divisor;
                        r_rem <= '0;
                    end
                end
                LOAD: begin
                    if (r_d == '0) begin
                        quotient    <= '1;
                        remainder   <= r_q;
                        div_by_zero <= 1'b1;
                    end else begin
                        r_count <= CW'(W);
                    end
                end
                ITER: begin
                    r_rem   <= w_rem_step;
                    r_q     <= w_q_step;
                    r_count <= r_count - CW'(1);
                    if (w_last_step) begin
                        quotient    <= w_q_step;
                        remainder   <= w_rem_step[W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider: cycle model plus
//               directed and random division vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

    localparam int W  = 32;
    localparam int CW = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_divider #(.W(W), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-level model: an accepted start schedules done a fixed number of
    // cycles later with the arithmetic result; outputs hold between results.
    initial begin
        bit           m_active;
        bit           can_acc;
        int           m_t;
        int           m_done_t;
        logic [W-1:0] p_q, p_r, o_q, o_r;
        logic         p_dz, o_dz;
        m_active = 0; m_t = 0; m_done_t = 0;
        p_q = '0; p_r = '0; p_dz = 1'b0;
        o_q = '0; o_r = '0; o_dz = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_active = 0;
                o_q = '0; o_r = '0; o_dz = 1'b0;
            end else begin
                can_acc = !m_active || (m_t == m_done_t);
                if (m_active) begin
                    m_t++;
                    if (m_t > m_done_t) m_active = 0;
                end
                if (can_acc && start) begin
                    m_active = 1;
                    m_t = 1;
                    if (divisor == '0) begin
                        p_q = '1; p_r = dividend; p_dz = 1'b1; m_done_t = 2;
                    end else begin
                        p_q = dividend / divisor; p_r = dividend % divisor;
                        p_dz = 1'b0; m_done_t = W + 2;
                    end
                end
                if (m_active && m_t == m_done_t) begin
                    o_q = p_q; o_r = p_r; o_dz = p_dz;
                end
            end
            chk("model_busy", busy, m_active && m_t >= 1 && m_t < m_done_t);
            chk("model_done", done, m_active && m_t == m_done_t);
            chk("model_quotient", quotient, o_q);
            chk("model_remainder", remainder, o_r);
            chk("model_dbz", div_by_zero, o_dz);
        end
    end

    // Caller is at a negedge; leaves at the negedge of cycle 1.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1;
        dividend = a;
        divisor = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int first_n, output int lat, output int busy_n);
        lat = -1;
        busy_n = 0;
        for (int n = first_n; n < first_n + 200; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
            @(negedge clk);
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: actual=no done required=done within 200 cycles");
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int elat, input int ebusy);
        int lat, bn;
        launch(a, b);
        wait_done(1, lat, bn);
        chk({name, "_quotient"}, quotient, eq);
        chk({name, "_remainder"}, remainder, er);
        chk({name, "_dbz"}, div_by_zero, edz);
        chk({name, "_latency"}, lat, elat);
        chk({name, "_busy_cycles"}, bn, ebusy);
    endtask

    initial begin
        int lat, bn;
        bit seen;
        logic [W-1:0] a, b;
        logic [63:0] recon;

        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_quotient", quotient, 0);
        chk("reset_remainder", remainder, 0);
        chk("reset_dbz", div_by_zero, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33);
        do_op("d3_10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34, 33);
        do_op("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34, 33);
        do_op("d5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 1);

        // Start during busy must be ignored.
        launch(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(11, lat, bn);
        chk("ignored_latency", lat, 34);
        chk("ignored_busy_cycles", bn, 23);
        chk("ignored_quotient", quotient, 14);
        chk("ignored_remainder", remainder, 2);

        // Back-to-back start in the DONE cycle.
        chk("b2b_done_pulse", done, 1);
        launch(32'd9, 32'd3);
        wait_done(1, lat, bn);
        chk("b2b_latency", lat, 34);
        chk("b2b_quotient", quotient, 3);
        chk("b2b_remainder", remainder, 0);

        // Asynchronous reset mid-operation.
        launch(32'd100, 32'd7);
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_quotient", quotient, 0);
        chk("rst_mid_remainder", remainder, 0);
        chk("rst_mid_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("rst_no_done_after", seen, 0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 5000);
            if ($urandom_range(0, 2) == 0) b = $urandom;
            else b = $urandom_range(1, 1000);
            if (b == '0) b = 32'd1;
            launch(a, b);
            wait_done(1, lat, bn);
            recon = 64'(quotient) * 64'(b) + 64'(remainder);
            chk("rand_reconstruct", recon, 64'(a));
            chk("rand_rem_lt_div", remainder < b, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
